// File: rtl/psram_qpi_ctrl.sv
// QPI PSRAM initiator: single-word bus requests become 0xEB quad reads / 0x38 quad writes,
// preceded once after reset by an SPI-mode 0x35 QPI-enable when INIT_QPI is set.
module psram_qpi_ctrl #(
  parameter int DUMMY_CYCLES = 7,
  parameter bit INIT_QPI     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        psram_sck,
  output logic        psram_ce_n,
  output logic [3:0]  dio_out,
  output logic [3:0]  dio_oe,
  input  logic [3:0]  dio_in
);

  typedef enum logic [2:0] {INIT, IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, GAP} state_t;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        sck_n, ce_n_n, qpi_on, qpi_on_n;
  logic [3:0]  out_n, oe_n;
  logic        valid_n, err_n, ready_n, accept, bad_strb;

  logic        we_r;
  logic [23:0] addr_r;
  logic [31:0] wsh_r, rsh_r;
  logic [3:0]  wlen_r;

  logic        we_c;
  logic [23:0] addr_new, addr_c;
  logic [31:0] wsh_new, wsh_c;
  logic        addr_lsb_unused;

  function automatic logic strb_legal(input logic [3:0] s);
    case (s)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
      4'b0110, 4'b1100, 4'b0111, 4'b1110, 4'b1111: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] low_lane(input logic [3:0] s);
    if (s[0]) return 2'd0;
    if (s[1]) return 2'd1;
    if (s[2]) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [3:0] nib_count(input logic [3:0] s);
    logic [3:0] n;
    n = 4'(s[0]) + 4'(s[1]) + 4'(s[2]) + 4'(s[3]);
    return n << 1;
  endfunction

  function automatic logic [7:0] last_idx(input state_t s, input logic [3:0] wlen);
    case (s)
      INIT, RDATA: return 8'd7;
      CMD:         return 8'd1;
      ADDR:        return 8'd5;
      DUMMY:       return 8'(DUMMY_CYCLES - 1);
      WDATA:       return {4'd0, wlen} - 8'd1;
      default:     return 8'd1;
    endcase
  endfunction

  // Nibble presented on the pins for sck period c of state s.
  function automatic logic [3:0] nib(input state_t s, input logic [7:0] c, input logic we,
                                     input logic [23:0] a, input logic [31:0] w);
    logic [7:0]  cmd, en;
    logic [23:0] as;
    logic [31:0] ws;
    cmd = we ? 8'h38 : 8'hEB;
    en  = 8'h35;
    as  = a << {c[2:0], 2'b00};
    ws  = w >> {c[2:1], 3'b000};
    case (s)
      INIT:    return {3'b000, en[3'd7 - c[2:0]]};
      CMD:     return c[0] ? cmd[3:0] : cmd[7:4];
      ADDR:    return as[23:20];
      WDATA:   return c[0] ? ws[3:0] : ws[7:4];
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] oe_for(input state_t s);
    case (s)
      INIT:             return 4'b0001;
      CMD, ADDR, WDATA: return 4'b1111;
      default:          return 4'b0000;
    endcase
  endfunction

  // Nibble n0 arrives first; byte k is {n2k, n2k+1}.
  function automatic logic [31:0] rdata_order(input logic [31:0] r);
    return {r[7:0], r[15:8], r[23:16], r[31:24]};
  endfunction

  assign addr_lsb_unused = ^req_addr[1:0];
  assign addr_new = req_we ? {req_addr[23:2], low_lane(req_wstrb)} : {req_addr[23:2], 2'b00};
  assign wsh_new  = req_wdata >> {low_lane(req_wstrb), 3'b000};
  assign we_c     = accept ? req_we   : we_r;
  assign addr_c   = accept ? addr_new : addr_r;
  assign wsh_c    = accept ? wsh_new  : wsh_r;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sck_n    = psram_sck;
    ce_n_n   = psram_ce_n;
    qpi_on_n = qpi_on;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    accept   = 1'b0;
    bad_strb = req_we && !strb_legal(req_wstrb);
    case (state)
      IDLE: begin
        if (!qpi_on) begin
          state_n = INIT;
          cnt_n   = 8'd0;
          ce_n_n  = 1'b0;
        end else if (req_valid && req_ready) begin
          if (bad_strb) begin
            valid_n = 1'b1;
            err_n   = 1'b1;
          end else begin
            accept  = 1'b1;
            state_n = CMD;
            cnt_n   = 8'd0;
            ce_n_n  = 1'b0;
          end
        end
      end
      GAP: begin
        if (cnt == 8'd1) begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        if (!psram_sck) begin
          sck_n = 1'b1;
        end else begin
          sck_n = 1'b0;
          if (cnt == last_idx(state, wlen_r)) begin
            cnt_n = 8'd0;
            case (state)
              INIT: begin
                state_n  = GAP;
                qpi_on_n = 1'b1;
                ce_n_n   = 1'b1;
              end
              CMD:   state_n = ADDR;
              ADDR:  state_n = we_c ? WDATA : ((DUMMY_CYCLES > 0) ? DUMMY : RDATA);
              DUMMY: state_n = RDATA;
              default: begin
                state_n = GAP;
                ce_n_n  = 1'b1;
                valid_n = 1'b1;
              end
            endcase
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
    endcase
    out_n   = nib(state_n, cnt_n, we_c, addr_c, wsh_c);
    oe_n    = oe_for(state_n);
    ready_n = (state_n == IDLE) && qpi_on_n && !err_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      psram_sck  <= 1'b0;
      psram_ce_n <= 1'b1;
      dio_out    <= 4'h0;
      dio_oe     <= 4'h0;
      qpi_on     <= ~INIT_QPI;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      psram_sck  <= sck_n;
      psram_ce_n <= ce_n_n;
      dio_out    <= out_n;
      dio_oe     <= oe_n;
      qpi_on     <= qpi_on_n;
      req_ready  <= ready_n;
      resp_valid <= valid_n;
      resp_err   <= err_n;
      if (state == RDATA && state_n == GAP) resp_rdata <= rdata_order(rsh_r);
    end
  end

  // Request capture and read shift register carry data only.
  always_ff @(posedge clock) begin
    if (accept) begin
      we_r   <= req_we;
      addr_r <= addr_new;
      wsh_r  <= wsh_new;
      wlen_r <= nib_count(req_wstrb);
    end
    if (state == RDATA && !psram_sck) rsh_r <= {rsh_r[27:0], dio_in};
  end

endmodule

// File: tb/tb_psram_qpi_ctrl.sv
// Directed bench for psram_qpi_ctrl with a behavioural QPI PSRAM responder and pin logger.
module tb_psram_qpi_ctrl;

  localparam int DUMMY = 7;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        psram_sck, psram_ce_n;
  logic [3:0]  dio_out, dio_oe;
  logic [3:0]  dio_in = '0;

  psram_qpi_ctrl #(.DUMMY_CYCLES(DUMMY), .INIT_QPI(1'b1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .psram_sck(psram_sck), .psram_ce_n(psram_ce_n),
    .dio_out(dio_out), .dio_oe(dio_oe), .dio_in(dio_in)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Device model and pin logger, evaluated mid-cycle when DUT outputs are stable.
  logic [7:0]  mem [0:1023];
  logic [3:0]  log_out [0:63];
  logic [3:0]  log_oe [0:63];
  logic        loaded = 1'b0, dev_qpi = 1'b0, prev_ce = 1'b1, prev_sck = 1'b0;
  logic [7:0]  dev_sh = '0, rb;
  logic [23:0] dev_addr = '0;
  logic [3:0]  dev_hi = '0;
  int          nlog = 0, ce_falls = 0, rv_cnt = 0, j;

  always @(negedge clock) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[10'h104] = 8'h11; mem[10'h105] = 8'h22; mem[10'h106] = 8'h33; mem[10'h107] = 8'h44;
      mem[10'h300] = 8'h12; mem[10'h301] = 8'h34; mem[10'h302] = 8'h56; mem[10'h303] = 8'h78;
      loaded = 1'b1;
    end
    if (reset) dev_qpi = 1'b0;
    if (resp_valid) rv_cnt++;
    if (!psram_ce_n && prev_ce) begin
      nlog = 0; ce_falls++; dev_sh = '0; dev_addr = '0;
    end
    if (!psram_ce_n && psram_sck && !prev_sck) begin
      if (nlog < 64) begin log_out[nlog] = dio_out; log_oe[nlog] = dio_oe; end
      if (!dev_qpi) begin
        dev_sh = {dev_sh[6:0], dio_out[0]};
        if (nlog == 7 && dev_sh == 8'h35) dev_qpi = 1'b1;
      end else if (nlog < 2) begin
        dev_sh = {dev_sh[3:0], dio_out};
      end else if (nlog < 8) begin
        dev_addr = {dev_addr[19:0], dio_out};
      end else if (dev_sh == 8'h38) begin
        if (nlog % 2 == 0) dev_hi = dio_out;
        else mem[(int'(dev_addr[9:0]) + (nlog - 8) / 2) % 1024] = {dev_hi, dio_out};
      end
      nlog++;
    end
    if (!psram_ce_n && !psram_sck && dev_qpi && dev_sh == 8'hEB && nlog >= 8 + DUMMY) begin
      j = nlog - 8 - DUMMY;
      rb = mem[(int'(dev_addr[9:0]) + j / 2) % 1024];
      dio_in = (j % 2 == 0) ? rb[7:4] : rb[3:0];
    end
    prev_ce  = psram_ce_n;
    prev_sck = psram_sck;
  end

  function automatic logic [31:0] pack_n(input int first, input int count, input bit use_oe);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < count; i++) v = {v[27:0], use_oe ? log_oe[first + i] : log_out[first + i]};
    return v;
  endfunction

  task automatic do_req(input logic we, input logic [23:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rdata, output logic err,
                        output int lat);
    int n;
    logic busy_rdy;
    @(negedge clock);
    req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clock); n++; end
    check_val("req_ready", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0; req_addr = 24'hFFFFFF; req_wdata = 32'h5A5A5A5A; req_wstrb = 4'b1010;
    req_we = ~we;
    lat = 1;
    busy_rdy = req_ready;
    while (!resp_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
      busy_rdy |= req_ready;
    end
    rdata = resp_rdata;
    err   = resp_err;
    check_val("busy_ready", 32'(busy_rdy), 32'd0);
    @(posedge clock); #1;
    check_val("resp_pulse", 32'(resp_valid), 32'd0);
  endtask

  task automatic init_seq(output int low, output int gap);
    int n;
    n = 0;
    while (psram_ce_n && n < 50) begin @(negedge clock); n++; end
    low = 0;
    while (!psram_ce_n && low < 100) begin @(negedge clock); low++; end
    gap = 0;
    while (!req_ready && gap < 50) begin @(negedge clock); gap++; end
    #1;
  endtask

  task automatic check_init(input string tag);
    int low, gap;
    logic [7:0] bits;
    init_seq(low, gap);
    check_val({tag, "_ce_low"}, 32'(low), 32'd16);
    check_val({tag, "_gap"}, 32'(gap), 32'd2);
    bits = '0;
    for (int i = 0; i < 8; i++) bits = {bits[6:0], log_out[i][0]};
    check_val({tag, "_bits"}, 32'(bits), 32'h35);
    check_val({tag, "_oe"}, pack_n(0, 8, 1'b1), 32'h11111111);
    check_val({tag, "_rises"}, 32'(nlog), 32'd8);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, rv0, cf0, n;

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    check_val("rst_sck", 32'(psram_sck), 32'd0);
    check_val("rst_ce_n", 32'(psram_ce_n), 32'd1);
    check_val("rst_oe", 32'(dio_oe), 32'd0);
    check_val("rst_out", 32'(dio_out), 32'd0);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_valid", 32'(resp_valid), 32'd0);
    check_val("rst_err", 32'(resp_err), 32'd0);
    check_val("rst_rdata", resp_rdata, 32'd0);
    rv0 = rv_cnt;
    reset = 1'b0;
    check_init("init");
    check_val("init_no_resp", 32'(rv_cnt - rv0), 32'd0);

    do_req(1'b0, 24'h000106, 32'h0, 4'b0000, rd, er, lat);
    check_val("rd1_lat", 32'(lat), 32'd47);
    check_val("rd1_data", rd, 32'h44332211);
    check_val("rd1_err", 32'(er), 32'd0);
    check_val("rd1_cmdaddr", pack_n(0, 8, 1'b0), 32'hEB000104);
    check_val("rd1_cmd_oe", pack_n(0, 8, 1'b1), 32'hFFFFFFFF);
    check_val("rd1_dummy_oe", pack_n(8, 7, 1'b1), 32'h0);
    check_val("rd1_data_oe", pack_n(15, 8, 1'b1), 32'h0);
    check_val("rd1_rises", 32'(nlog), 32'd23);

    do_req(1'b1, 24'h000200, 32'hDEADBEEF, 4'b1111, rd, er, lat);
    check_val("wr1_lat", 32'(lat), 32'd33);
    check_val("wr1_err", 32'(er), 32'd0);
    check_val("wr1_cmdaddr", pack_n(0, 8, 1'b0), 32'h38000200);
    check_val("wr1_data", pack_n(8, 8, 1'b0), 32'hEFBEADDE);
    check_val("wr1_oe", pack_n(8, 8, 1'b1), 32'hFFFFFFFF);
    check_val("wr1_rises", 32'(nlog), 32'd16);

    do_req(1'b0, 24'h000200, 32'h0, 4'b0000, rd, er, lat);
    check_val("rd2_lat", 32'(lat), 32'd47);
    check_val("rd2_data", rd, 32'hDEADBEEF);

    do_req(1'b1, 24'h000300, 32'hCAFE0000, 4'b1100, rd, er, lat);
    check_val("wr2_lat", 32'(lat), 32'd25);
    check_val("wr2_cmdaddr", pack_n(0, 8, 1'b0), 32'h38000302);
    check_val("wr2_data", pack_n(8, 4, 1'b0), 32'h0000FECA);
    check_val("wr2_rises", 32'(nlog), 32'd12);

    do_req(1'b0, 24'h000300, 32'h0, 4'b0000, rd, er, lat);
    check_val("rd3_data", rd, 32'hCAFE3412);

    cf0 = ce_falls;
    do_req(1'b1, 24'h000400, 32'h12345678, 4'b0101, rd, er, lat);
    check_val("bad0101_lat", 32'(lat), 32'd1);
    check_val("bad0101_err", 32'(er), 32'd1);
    do_req(1'b1, 24'h000400, 32'h12345678, 4'b0000, rd, er, lat);
    check_val("bad0000_lat", 32'(lat), 32'd1);
    check_val("bad0000_err", 32'(er), 32'd1);
    repeat (3) @(negedge clock);
    check_val("bad_no_ce", 32'(ce_falls - cf0), 32'd0);

    // Reset in the middle of a read's data phase.
    @(negedge clock);
    req_we = 1'b0; req_addr = 24'h000104; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clock); n++; end
    check_val("rst_rd_ready", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    n = 0;
    while (nlog < 18 && n < 200) begin @(negedge clock); #1; n++; end
    check_val("rst_in_rdata", 32'(nlog >= 18), 32'd1);
    rv0 = rv_cnt;
    reset = 1'b1;
    #1;
    check_val("mid_rst_ce_n", 32'(psram_ce_n), 32'd1);
    check_val("mid_rst_oe", 32'(dio_oe), 32'd0);
    check_val("mid_rst_sck", 32'(psram_sck), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_init("reinit");
    check_val("mid_rst_no_resp", 32'(rv_cnt - rv0), 32'd0);
    do_req(1'b0, 24'h000104, 32'h0, 4'b0000, rd, er, lat);
    check_val("rd4_lat", 32'(lat), 32'd47);
    check_val("rd4_data", rd, 32'h44332211);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/psram_qpi_ctrl.md
Name: psram_qpi_ctrl

Overview:
- Initiator for the external QPI PSRAM serial interface; the PSRAM chip is the responder.
- Converts single-word requests from the on-chip bus bridge into pin-level transactions:
  - 0xEB quad read
  - 0x38 quad write
  - one-time 0x35 QPI-enable command sent in SPI mode after reset.
- Drives psram_sck and psram_ce_n; splits dio into out/oe/in for the top-level tristate.

Parameters:
- DUMMY_CYCLES, 7, sck rising edges between last address nibble and first read-data nibble.
- INIT_QPI, 1, when 1 send 0x35 (SPI mode) before the first request; when 0 start in QPI mode.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller idle and initialised
- req_we  input  1  1=write, 0=read
- req_addr  input  24  byte address; bits [1:0] ignored for reads
- req_wdata  input  32  write data, byte lane k = bits [8k+7:8k]
- req_wstrb  input  4  byte enables
- resp_valid  output  1  one-cycle completion pulse, no backpressure
- resp_err  output  1  qualifies resp_valid; illegal strobe
- resp_rdata  output  32  read data, valid with resp_valid
- psram_sck  output  1  serial clock
- psram_ce_n  output  1  chip select, active low
- dio_out  output  4  data to pins
- dio_oe  output  4  per-bit output enable
- dio_in  input  4  data from pins

Behaviour:
- Reset values:
  - psram_sck=0, psram_ce_n=1, dio_oe=0, dio_out=0
  - req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0
  - qpi_on=0 (qpi_on=1 when INIT_QPI=0)
- Reset-scoped device state: the PSRAM device is reset together with the system, so its QPI state is cleared by reset.
- sck generation: sck = clock/2 while ce_n=0, idle low.
  - Each sck period = low clock then high clock.
  - The controller updates dio_out/dio_oe in the clock where sck goes low (or where ce_n falls).
  - dio_in is sampled at the clock edge on which sck rises.
- States: INIT, IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, GAP.
  - INIT (from reset when INIT_QPI=1):
    - ce_n low; 0x35 sent MSB first on dio_out[0], dio_oe=0001, 8 sck rises.
    - Then GAP; qpi_on=1.
  - IDLE: req_ready=1 iff qpi_on. Accept on req_valid&req_ready (cycle 0); ce_n falls in cycle 1.
  - CMD: 2 nibbles, high first (EB or 38), dio_oe=1111.
  - ADDR: 6 nibbles of the 24-bit address, MSB first, dio_oe=1111.
  - DUMMY (read only): DUMMY_CYCLES sck rises, dio_oe=0000.
  - RDATA: 8 sck rises, each sampling one nibble n0..n7.
    - resp_rdata = {n6,n7,n4,n5,n2,n3,n0,n1} (byte k = {n2k,n2k+1}).
    - Reads are word aligned: sent address = {req_addr[23:2],2'b00}.
  - WDATA: bytes sent in ascending lane order, high nibble first, dio_oe=1111.
    - Sent address = {req_addr[23:2], index of lowest set strobe bit}.
  - GAP: ce_n=1, sck=0, dio_oe=0 for 2 clocks; then IDLE.
    - resp_valid pulses in the first GAP clock (not after INIT).
- Write strobes:
  - Legal (contiguous, nonzero): 0001, 0010, 0100, 1000, 0011, 0110, 1100, 0111, 1110, 1111.
  - Nibble count = 2 x popcount.
  - Zero or non-contiguous strobe: no pin activity; resp_valid=1, resp_err=1 in cycle 1; back to IDLE.
- Latency: with N = sck rises in the transaction, resp_valid asserts 2N+1 clocks after the accept cycle.
  - Read: N = 8+DUMMY_CYCLES+8 = 23 -> 47 clocks.
  - Full-word write: N = 16 -> 33 clocks.
- req_* fields are captured at accept; later changes are ignored.
- No request is accepted while busy; req_ready=0 from accept until GAP ends.
- Reset mid-transaction: all outputs return to reset values immediately (ce_n=1 asynchronously); the pending request is dropped with no resp_valid; INIT reruns.

Test Plan:
- Reset release, INIT_QPI=1 -> 8 sck rises with dio_out[0] = 0,0,1,1,0,1,0,1 and dio_oe=0001; ce_n high 2 clocks; req_ready=1.
- Read 0x000106, memory bytes at 0x104..0x107 = 11 22 33 44:
  - pins carry E,B,0,0,0,1,0,4 then 7 dummy rises with oe=0.
  - resp_rdata=0x44332211, resp_valid exactly 47 clocks after accept.
- Write 0x000200, wdata 0xDEADBEEF, wstrb 1111:
  - nibbles E,F,B,E,A,D,D,E after the address; 16 sck rises.
  - Read-back returns 0xDEADBEEF; resp_valid at 33 clocks.
- Write wstrb 1100, wdata 0xCAFE0000, addr 0x000300:
  - sent address 0x000302; nibbles F,E,C,A; 12 rises.
  - Read of 0x300 shows only bytes 2..3 changed.
- Write wstrb 0101 -> no ce_n activity; resp_valid with resp_err=1 in cycle 1. wstrb 0000 gives the same result.
- Assert reset during RDATA:
  - ce_n=1 and dio_oe=0 the same cycle; no resp_valid.
  - After release, INIT repeats and the following read returns correct data.
